store_run_ctrl: RTL and testbench
=================================

Name: store_run_ctrl

Overview:
- Controller that sequences the overflow-monitor range buffer used by the heap-safety checks beside the branch unit.
- Tracks runs of contiguous non-sp stores and times them out; commits long runs to the range buffer over a valid/ready write port.
- Qualifies loads against committed and in-flight ranges, and raises a crash pulse when a jump follows a tainted load.

Parameters:
ADDR_W, 32, address width of store/load addresses and range bounds
TIMEOUT, 10, non-store instruction ticks an open run survives without a new store
MIN_RUN, 5, minimum stores in a run for it to be committed to the buffer
CNT_W, 8, width of the saturating run-length counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
store_valid_i  in  1  issued store this cycle
store_addr_i  in  ADDR_W  effective store address (operand_a + imm)
store_size_i  in  2  0=byte, 1=half, 2=word, 3=reserved
store_is_sp_i  in  1  store base register is x2; store is ignored
tick_i  in  1  non-store, non-load instruction issued
load_valid_i  in  1  issued load this cycle
load_addr_i  in  ADDR_W  effective load address
lookup_addr_o  out  ADDR_W  address presented to the buffer lookup (= load_addr_i, combinational)
lookup_hit_i  in  1  buffer reports lookup_addr_o inside a committed range (combinational)
jump_valid_i  in  1  issued JAL/JALR this cycle
buf_we_o  out  1  write request to range buffer
buf_first_o  out  ADDR_W  committed range first address
buf_last_o  out  ADDR_W  committed range last address
buf_ready_i  in  1  buffer accepts write this cycle
run_active_o  out  1  a run is open
crash_o  out  1  one-cycle crash pulse
drop_o  out  1  one-cycle pulse: closed run lost, pending slot busy

Behaviour:
- Reset values: all outputs 0; state IDLE; first/last/count/timer/taint/pending all 0.
- Reset mid-operation clears everything, including an unaccepted pending write. No write completes after reset.
- Store eligible iff store_valid_i & ~store_is_sp_i & store_size_i != 3. Ineligible stores have no effect and are not ticks.
- bytes = 1 << store_size_i.
- Contiguous iff store_addr_i == last_q + bytes, computed in ADDR_W+1 bits. A carry out means not contiguous, so there is no wrap-around run.
- Run FSM, two states:
  - IDLE: eligible store -> RUN; first=last=addr, count=1, timer=TIMEOUT.
  - RUN + contiguous store: last=addr, count+1 saturating at 2^CNT_W-1, timer=TIMEOUT.
  - RUN + non-contiguous store: close current run. Start a new run on this store in the same cycle; stays RUN.
  - RUN + tick_i, timer>0: timer-1.
  - RUN + tick_i, timer==0: close run -> IDLE.
  - Store and tick_i in the same cycle: store wins, tick ignored.
- Close: if count >= MIN_RUN, load pending slot {first,last} for the next cycle. If the slot is still valid and not being accepted this cycle, the new range is dropped and drop_o pulses. count < MIN_RUN discards silently.
- Write port:
  - buf_we_o = pending_valid_q; buf_first_o/buf_last_o come straight from pending registers.
  - Handshake completes on buf_we_o & buf_ready_i; pending clears next cycle.
  - Same-cycle accept plus new close loads the new range, with no drop.
  - Data is held stable while buf_we_o is high and not accepted.
- Latency: the close cycle is N; buf_we_o rises at N+1.
- Load check:
  - hit = lookup_hit_i | (run_active & load_addr_i >= first_q & load_addr_i <= last_q + bytes_last - 1).
  - bytes_last is the size of the last store in the run (registered).
  - On load_valid_i: taint_q <= hit. Taint is held otherwise.
- Jump check: jump_valid_i & taint_q -> crash_o=1 next cycle, for one cycle; taint_q clears.
- Load and jump in the same cycle: the jump uses the old taint_q; the load updates taint.
- run_active_o = (state==RUN).

Test Plan:
- 5 SW at 0x1000,0x1004,...,0x1010, then 11 ticks -> IDLE after tick 11; buf_we_o=1 with first=0x1000, last=0x1010; held until buf_ready_i, cleared the cycle after.
- 4 SW contiguous, then SW 0x2000 -> no buf_we_o; new run first=last=0x2000, run_active_o stays 1.
- 6 SB 0x3000..0x3005, then SH 0x4000 with buf_ready_i=0; then 5 SW 0x5000..0x5010 + break store -> first range pending; second close pulses drop_o; pending still 0x3000/0x3005.
- Store sp-based at 0x1004 during run from 0x1000 -> ignored; timer not reloaded, last=0x1000.
- Committed range 0x1000-0x1013 (lookup_hit_i=1 for 0x1008), LW 0x1008 then JALR -> crash_o=1 for one cycle; LW 0x9000 then JAL -> crash_o=0.
- Contiguity overflow: SW last=0xFFFFFFFC, next SW 0x00000000 -> non-contiguous, new run. Assert rst_ni mid-pending -> buf_we_o=0 immediately, no write after release.

Source files
------------

// File: rtl/store_run_ctrl_if.sv
// Range-buffer write port: valid/ready handshake carrying one {first,last} range.
interface store_run_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              buf_we_o;
  logic [ADDR_W-1:0] buf_first_o;
  logic [ADDR_W-1:0] buf_last_o;
  logic              buf_ready_i;

  modport master (output buf_we_o, buf_first_o, buf_last_o, input buf_ready_i);
  modport slave  (input buf_we_o, buf_first_o, buf_last_o, output buf_ready_i);
endinterface

// File: rtl/store_run_ctrl.sv
// Tracks contiguous non-sp store runs, commits long runs to the range buffer,
// and raises a crash pulse when a jump follows a load inside a guarded range.
module store_run_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 10,
  parameter int unsigned MIN_RUN = 5,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              store_valid_i,
  input  logic [ADDR_W-1:0] store_addr_i,
  input  logic [1:0]        store_size_i,
  input  logic              store_is_sp_i,
  input  logic              tick_i,
  input  logic              load_valid_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic [ADDR_W-1:0] lookup_addr_o,
  input  logic              lookup_hit_i,
  input  logic              jump_valid_i,
  store_run_ctrl_if.master  buf_if,
  output logic              run_active_o,
  output logic              crash_o,
  output logic              drop_o
);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] first_q, first_d, last_q, last_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        size_last_q, size_last_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_first_q, pend_first_d, pend_last_q, pend_last_d;
  logic              taint_q, taint_d;
  logic              crash_q, crash_d;
  logic              drop_q, drop_d;

  logic              eligible, contiguous, close, commit, accept, hit;
  logic [ADDR_W:0]   bytes_st, bytes_last, next_exp, range_end;

  // Contiguity and range end use one extra bit so a carry never aliases low addresses.
  assign eligible   = store_valid_i & ~store_is_sp_i & (store_size_i != 2'd3);
  assign bytes_st   = {{ADDR_W{1'b0}}, 1'b1} << store_size_i;
  assign bytes_last = {{ADDR_W{1'b0}}, 1'b1} << size_last_q;
  assign next_exp   = {1'b0, last_q} + bytes_st;
  assign contiguous = (next_exp == {1'b0, store_addr_i});
  assign range_end  = {1'b0, last_q} + bytes_last - 1'b1;
  assign hit        = lookup_hit_i | ((state_q == RUN) &&
                      ({1'b0, load_addr_i} >= {1'b0, first_q}) &&
                      ({1'b0, load_addr_i} <= range_end));

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    last_d      = last_q;
    count_d     = count_q;
    timer_d     = timer_q;
    size_last_d = size_last_q;
    close       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d     = RUN;
          first_d     = store_addr_i;
          last_d      = store_addr_i;
          count_d     = CNT_W'(1);
          timer_d     = TMR_W'(TIMEOUT);
          size_last_d = store_size_i;
        end
      end
      RUN: begin
        if (eligible) begin
          if (contiguous) begin
            last_d      = store_addr_i;
            count_d     = (count_q == '1) ? count_q : count_q + 1'b1;
            timer_d     = TMR_W'(TIMEOUT);
            size_last_d = store_size_i;
          end else begin
            close       = 1'b1;
            first_d     = store_addr_i;
            last_d      = store_addr_i;
            count_d     = CNT_W'(1);
            timer_d     = TMR_W'(TIMEOUT);
            size_last_d = store_size_i;
          end
        end else if (tick_i) begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            close   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An accept in the same cycle frees the slot, so a concurrent commit is never dropped.
  assign commit = close & (count_q >= CNT_W'(MIN_RUN));
  assign accept = pend_valid_q & buf_if.buf_ready_i;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_first_d = pend_first_q;
    pend_last_d  = pend_last_q;
    drop_d       = 1'b0;
    if (commit && (!pend_valid_q || accept)) begin
      pend_valid_d = 1'b1;
      pend_first_d = first_q;
      pend_last_d  = last_q;
    end else if (commit) begin
      drop_d = 1'b1;
    end else if (accept) begin
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    crash_d = jump_valid_i & taint_q;
    taint_d = taint_q;
    if (load_valid_i) begin
      taint_d = hit;
    end else if (crash_d) begin
      taint_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      first_q      <= '0;
      last_q       <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      size_last_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_first_q <= '0;
      pend_last_q  <= '0;
      taint_q      <= 1'b0;
      crash_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      last_q       <= last_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      size_last_q  <= size_last_d;
      pend_valid_q <= pend_valid_d;
      pend_first_q <= pend_first_d;
      pend_last_q  <= pend_last_d;
      taint_q      <= taint_d;
      crash_q      <= crash_d;
      drop_q       <= drop_d;
    end
  end

  assign lookup_addr_o      = load_addr_i;
  assign buf_if.buf_we_o    = pend_valid_q;
  assign buf_if.buf_first_o = pend_first_q;
  assign buf_if.buf_last_o  = pend_last_q;
  assign run_active_o       = (state_q == RUN);
  assign crash_o            = crash_q;
  assign drop_o             = drop_q;
endmodule

// File: tb/tb_store_run_ctrl.sv
// Directed bench for store_run_ctrl: run commit/timeout, drop, sp filtering, taint/crash, wrap and reset.
module tb_store_run_ctrl;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        store_valid = 1'b0;
  logic [31:0] store_addr = '0;
  logic [1:0]  store_size = '0;
  logic        store_is_sp = 1'b0;
  logic        tick = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] lookup_addr;
  logic        lookup_hit;
  logic        jump_valid = 1'b0;
  logic        run_active, crash, drop;
  logic        buf_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  store_run_ctrl_if #(.ADDR_W(32)) bif ();

  // Committed-range model of the buffer: 0x1000..0x1013 when enabled.
  assign lookup_hit = buf_en && (lookup_addr >= 32'h1000) && (lookup_addr <= 32'h1013);

  store_run_ctrl #(.ADDR_W(32), .TIMEOUT(10), .MIN_RUN(5), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .store_valid_i(store_valid), .store_addr_i(store_addr), .store_size_i(store_size),
    .store_is_sp_i(store_is_sp), .tick_i(tick),
    .load_valid_i(load_valid), .load_addr_i(load_addr),
    .lookup_addr_o(lookup_addr), .lookup_hit_i(lookup_hit),
    .jump_valid_i(jump_valid), .buf_if(bif.master),
    .run_active_o(run_active), .crash_o(crash), .drop_o(drop)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
    store_valid = 1'b0; store_is_sp = 1'b0; tick = 1'b0;
    load_valid = 1'b0; jump_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] s, input logic sp);
    store_valid = 1'b1; store_addr = a; store_size = s; store_is_sp = sp; cyc();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin tick = 1'b1; cyc(); end
  endtask

  task automatic do_load(input logic [31:0] a);
    load_valid = 1'b1; load_addr = a; cyc();
  endtask

  task automatic do_jump();
    jump_valid = 1'b1; cyc();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; bif.buf_ready_i = 1'b0; buf_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    bif.buf_ready_i = 1'b0;
    #1;
    checks++; if (bif.buf_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", bif.buf_we_o); end
    checks++; if (bif.buf_first_o !== 32'h0 || bif.buf_last_o !== 32'h0) begin failures++; $display("FAIL reset_range got=%h/%h exp=0/0", bif.buf_first_o, bif.buf_last_o); end
    checks++; if ({run_active, crash, drop} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {run_active, crash, drop}); end
    do_reset();
  endtask

  task automatic test_commit_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) do_store(32'h1000 + 32'(4 * i), 2'd2, 1'b0);
    checks++; if (run_active !== 1'b1) begin failures++; $display("FAIL commit_run_open got=%0b exp=1", run_active); end
    do_ticks(10);
    checks++; if (run_active !== 1'b1 || bif.buf_we_o !== 1'b0) begin failures++; $display("FAIL commit_tick10 got=%0b/%0b exp=1/0", run_active, bif.buf_we_o); end
    do_ticks(1);
    checks++; if (run_active !== 1'b0) begin failures++; $display("FAIL commit_tick11_idle got=%0b exp=0", run_active); end
    checks++; if (bif.buf_we_o !== 1'b1 || bif.buf_first_o !== 32'h1000 || bif.buf_last_o !== 32'h1010) begin failures++; $display("FAIL commit_write got=%0b %h/%h exp=1 00001000/00001010", bif.buf_we_o, bif.buf_first_o, bif.buf_last_o); end
    cyc(); cyc(); cyc();
    checks++; if (bif.buf_we_o !== 1'b1 || bif.buf_first_o !== 32'h1000 || bif.buf_last_o !== 32'h1010) begin failures++; $display("FAIL commit_hold got=%0b %h/%h exp=1 00001000/00001010", bif.buf_we_o, bif.buf_first_o, bif.buf_last_o); end
    load_addr = 32'hABCD0123; #1;
    checks++; if (lookup_addr !== 32'hABCD0123) begin failures++; $display("FAIL lookup_addr got=%h exp=abcd0123", lookup_addr); end
    bif.buf_ready_i = 1'b1; cyc(); bif.buf_ready_i = 1'b0;
    checks++; if (bif.buf_we_o !== 1'b0 || drop !== 1'b0) begin failures++; $display("FAIL commit_accept got=%0b/%0b exp=0/0", bif.buf_we_o, drop); end
  endtask

  task automatic test_short_run();
    do_reset();
    for (int i = 0; i < 4; i++) do_store(32'h1000 + 32'(4 * i), 2'd2, 1'b0);
    do_store(32'h2000, 2'd2, 1'b0);
    checks++; if (bif.buf_we_o !== 1'b0 || run_active !== 1'b1) begin failures++; $display("FAIL short_no_commit got=%0b/%0b exp=0/1", bif.buf_we_o, run_active); end
    cyc();
    checks++; if (bif.buf_we_o !== 1'b0) begin failures++; $display("FAIL short_no_commit_late got=%0b exp=0", bif.buf_we_o); end
    do_load(32'h2003); do_jump();
    checks++; if (crash !== 1'b1) begin failures++; $display("FAIL short_hit_last_byte got=%0b exp=1", crash); end
    do_load(32'h2004); do_jump();
    checks++; if (crash !== 1'b0) begin failures++; $display("FAIL short_past_end got=%0b exp=0", crash); end
    do_load(32'h1000); do_jump();
    checks++; if (crash !== 1'b0) begin failures++; $display("FAIL short_old_run_gone got=%0b exp=0", crash); end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 6; i++) do_store(32'h3000 + 32'(i), 2'd0, 1'b0);
    do_store(32'h4000, 2'd1, 1'b0);
    checks++; if (bif.buf_we_o !== 1'b1 || bif.buf_first_o !== 32'h3000 || bif.buf_last_o !== 32'h3005) begin failures++; $display("FAIL drop_first_pending got=%0b %h/%h exp=1 00003000/00003005", bif.buf_we_o, bif.buf_first_o, bif.buf_last_o); end
    for (int i = 0; i < 5; i++) do_store(32'h5000 + 32'(4 * i), 2'd2, 1'b0);
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL drop_short_silent got=%0b exp=0", drop); end
    do_store(32'h6000, 2'd2, 1'b0);
    checks++; if (drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%0b exp=1", drop); end
    checks++; if (bif.buf_first_o !== 32'h3000 || bif.buf_last_o !== 32'h3005) begin failures++; $display("FAIL drop_pending_kept got=%h/%h exp=00003000/00003005", bif.buf_first_o, bif.buf_last_o); end
    for (int i = 1; i < 5; i++) do_store(32'h6000 + 32'(4 * i), 2'd2, 1'b0);
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL drop_one_cycle got=%0b exp=0", drop); end
    bif.buf_ready_i = 1'b1;
    do_store(32'h7000, 2'd2, 1'b0);
    checks++; if (bif.buf_we_o !== 1'b1 || bif.buf_first_o !== 32'h6000 || bif.buf_last_o !== 32'h6010 || drop !== 1'b0) begin failures++; $display("FAIL accept_and_close got=%0b %h/%h drop=%0b exp=1 00006000/00006010 drop=0", bif.buf_we_o, bif.buf_first_o, bif.buf_last_o, drop); end
    cyc();
    checks++; if (bif.buf_we_o !== 1'b0) begin failures++; $display("FAIL accept_second got=%0b exp=0", bif.buf_we_o); end
    bif.buf_ready_i = 1'b0;
  endtask

  task automatic test_sp_ignored();
    do_reset();
    do_store(32'h1000, 2'd2, 1'b0);
    do_ticks(5);
    do_store(32'h1004, 2'd2, 1'b1);
    do_store(32'h1004, 2'd3, 1'b0);
    do_load(32'h1004); do_jump();
    checks++; if (crash !== 1'b0) begin failures++; $display("FAIL sp_last_unchanged got=%0b exp=0", crash); end
    do_load(32'h1003); do_jump();
    checks++; if (crash !== 1'b1) begin failures++; $display("FAIL sp_run_range got=%0b exp=1", crash); end
    do_ticks(5);
    checks++; if (run_active !== 1'b1) begin failures++; $display("FAIL sp_not_tick got=%0b exp=1", run_active); end
    do_ticks(1);
    checks++; if (run_active !== 1'b0) begin failures++; $display("FAIL sp_no_reload got=%0b exp=0", run_active); end
  endtask

  task automatic test_crash();
    do_reset();
    buf_en = 1'b1;
    do_load(32'h1008);
    checks++; if (crash !== 1'b0) begin failures++; $display("FAIL crash_load_only got=%0b exp=0", crash); end
    do_jump();
    checks++; if (crash !== 1'b1) begin failures++; $display("FAIL crash_pulse got=%0b exp=1", crash); end
    cyc();
    checks++; if (crash !== 1'b0) begin failures++; $display("FAIL crash_one_cycle got=%0b exp=0", crash); end
    do_jump();
    checks++; if (crash !== 1'b0) begin failures++; $display("FAIL crash_taint_cleared got=%0b exp=0", crash); end
    do_load(32'h9000); do_jump();
    checks++; if (crash !== 1'b0) begin failures++; $display("FAIL crash_clean_load got=%0b exp=0", crash); end
    do_load(32'h1008);
    load_valid = 1'b1; load_addr = 32'h9000; jump_valid = 1'b1; cyc();
    checks++; if (crash !== 1'b1) begin failures++; $display("FAIL crash_same_cycle_old_taint got=%0b exp=1", crash); end
    do_jump();
    checks++; if (crash !== 1'b0) begin failures++; $display("FAIL crash_same_cycle_new_taint got=%0b exp=0", crash); end
    buf_en = 1'b0;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int i = 0; i < 5; i++) do_store(32'hFFFFFFEC + 32'(4 * i), 2'd2, 1'b0);
    do_store(32'h00000000, 2'd2, 1'b0);
    checks++; if (bif.buf_we_o !== 1'b1 || bif.buf_first_o !== 32'hFFFFFFEC || bif.buf_last_o !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_not_contiguous got=%0b %h/%h exp=1 ffffffec/fffffffc", bif.buf_we_o, bif.buf_first_o, bif.buf_last_o); end
    checks++; if (run_active !== 1'b1) begin failures++; $display("FAIL wrap_new_run got=%0b exp=1", run_active); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (bif.buf_we_o !== 1'b0 || run_active !== 1'b0) begin failures++; $display("FAIL async_reset got=%0b/%0b exp=0/0", bif.buf_we_o, run_active); end
    @(posedge clk); #1 rst_ni = 1'b1; bif.buf_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (bif.buf_we_o !== 1'b0) begin failures++; $display("FAIL no_write_after_reset cyc=%0d got=%0b exp=0", i, bif.buf_we_o); end
    end
    bif.buf_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_commit_timeout();
    test_short_run();
    test_drop();
    test_sp_ignored();
    test_crash();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
